// File: rtl/spi_frame_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_tx_pkg
// Description : Shared state encoding and default sizing for the SPI frame
//               transmitter.
// Revision    : 1.0  initial release
// ============================================================================
package spi_tx_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        GAP   = 3'd3
    } spi_tx_state_t;

    localparam int SPI_DATA_W  = 16;
    localparam int SPI_CLK_DIV = 24;
    localparam int SPI_GAP_CYC = 4;

endpackage
`default_nettype wire

// File: rtl/spi_frame_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : spi_frame_tx_if
// Description : Word handshake plus SPI pins of the frame transmitter.
//               'master' is the transmitter side, 'slave' the word source
//               and SPI observer.
// Revision    : 1.0  initial release
// ============================================================================
interface spi_frame_tx_if
    import spi_tx_pkg::*;
#(
    parameter int DATA_W = SPI_DATA_W
);
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              busy;
    logic              done;
    logic              sclk;
    logic              cs;
    logic              sdo;

    modport master (
        input  tx_data, tx_valid,
        output tx_ready, busy, done, sclk, cs, sdo
    );

    modport slave (
        output tx_data, tx_valid,
        input  tx_ready, busy, done, sclk, cs, sdo
    );
endinterface
`default_nettype wire

// File: rtl/spi_frame_tx_clkgen.sv
`default_nettype none
// ============================================================================
// Module      : spi_tx_clkgen
// Description : sclk half-period tick generator; counts 0..CLK_DIV-1 and
//               ticks on the last count. i_clear holds the count at zero.
// Revision    : 1.0  initial release
// ============================================================================
module spi_tx_clkgen
    import spi_tx_pkg::*;
#(
    parameter int CLK_DIV = SPI_CLK_DIV
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic i_clear,
    output logic      o_tick
);
    localparam int c_cnt_w = $clog2(CLK_DIV);

    logic [c_cnt_w-1:0] r_cnt;
    logic               w_wrap;

    assign w_wrap = (r_cnt == c_cnt_w'(CLK_DIV - 1));
    assign o_tick = w_wrap & ~i_clear;

    always_ff @(posedge clk) begin
        if (!reset || i_clear) begin
            r_cnt <= '0;
        end else if (w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_cnt_w'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/spi_frame_tx.sv
`default_nettype none
// ============================================================================
// Module      : spi_frame_tx
// Description : SPI mode-0 master transmitter, MSB first, cs active low.
//               Define SPI_TX_HOLD_EN for a one-word holding register.
// Revision    : 1.0  initial release
// ============================================================================
module spi_frame_tx
    import spi_tx_pkg::*;
#(
    parameter int DATA_W  = SPI_DATA_W,
    parameter int CLK_DIV = SPI_CLK_DIV,
    parameter int GAP_CYC = SPI_GAP_CYC
) (
    input  wire logic       clk,
    input  wire logic       reset,
    spi_frame_tx_if.master  bus
);
    localparam int c_bit_w = $clog2(DATA_W);
    localparam int c_gap_w = $clog2(GAP_CYC + 1);

    spi_tx_state_t       r_state;
    spi_tx_state_t       w_next;
    logic [DATA_W-1:0]   r_shift;
    logic [c_bit_w-1:0]  r_bit_cnt;
    logic [c_gap_w-1:0]  r_gap_cnt;
    logic                r_phase;      // 0: sclk high half, 1: sclk low half
    logic                w_tick;
    logic                w_clear;
    logic                w_ready;
    logic                w_accept;
    logic                w_gap_end;
    logic                w_load;
    logic                w_last_bit;

`ifdef SPI_TX_HOLD_EN
    logic [DATA_W-1:0]   r_hold;
    logic                r_hold_full;
    logic                w_to_hold;

    assign w_ready   = ~r_hold_full;
    // Accepts go to the hold slot unless they can start a frame right now
    assign w_to_hold = w_accept && (r_state != IDLE) && !(w_gap_end && !r_hold_full);
`else
    assign w_ready   = (r_state == IDLE);
`endif

    assign bus.tx_ready = w_ready & reset;
    assign w_accept     = bus.tx_valid & bus.tx_ready;
    assign w_gap_end    = (r_state == GAP) && (r_gap_cnt == c_gap_w'(GAP_CYC - 1));
    assign w_last_bit   = (r_bit_cnt == c_bit_w'(DATA_W - 1));
    assign w_clear      = (r_state != SETUP) && (r_state != SHIFT);

    spi_tx_clkgen #(
        .CLK_DIV (CLK_DIV)
    ) u_clkgen (
        .clk     (clk),
        .reset   (reset),
        .i_clear (w_clear),
        .o_tick  (w_tick)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_load   = 1'b0;
        bus.cs   = 1'b1;
        bus.sclk = 1'b0;
        bus.sdo  = 1'b0;
        bus.done = 1'b0;
        bus.busy = (r_state != IDLE);
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next = SETUP;
                    w_load = 1'b1;
                end
            end
            SETUP: begin
                bus.cs  = 1'b0;
                bus.sdo = r_shift[DATA_W-1];
                if (w_tick) begin
                    w_next = SHIFT;
                end
            end
            SHIFT: begin
                bus.cs   = 1'b0;
                bus.sclk = ~r_phase;
                bus.sdo  = r_shift[DATA_W-1];
                if (w_tick && r_phase && w_last_bit) begin
                    w_next = GAP;
                end
            end
            GAP: begin
                bus.done = (r_gap_cnt == '0);
                if (w_gap_end) begin
`ifdef SPI_TX_HOLD_EN
                    if (r_hold_full || w_accept) begin
                        w_next = SETUP;
                        w_load = 1'b1;
                    end else begin
                        w_next = IDLE;
                    end
`else
                    w_next = IDLE;
`endif
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_gap_cnt <= '0;
            r_phase   <= 1'b0;
        end else begin
            if (w_load) begin
`ifdef SPI_TX_HOLD_EN
                r_shift <= r_hold_full ? r_hold : bus.tx_data;
`else
                r_shift <= bus.tx_data;
`endif
            end else if (r_state == SHIFT && w_tick && !r_phase) begin
                // Shift on the falling-edge tick so sdo changes with sclk low
                r_shift <= {r_shift[DATA_W-2:0], 1'b0};
            end

            if (r_state != SHIFT) begin
                r_phase   <= 1'b0;
                r_bit_cnt <= '0;
            end else if (w_tick) begin
                r_phase <= ~r_phase;
                if (r_phase) begin
                    r_bit_cnt <= r_bit_cnt + c_bit_w'(1);
                end
            end

            if (r_state != GAP || w_gap_end) begin
                r_gap_cnt <= '0;
            end else begin
                r_gap_cnt <= r_gap_cnt + c_gap_w'(1);
            end
        end
    end

`ifdef SPI_TX_HOLD_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_hold      <= '0;
            r_hold_full <= 1'b0;
        end else if (w_to_hold) begin
            r_hold      <= bus.tx_data;
            r_hold_full <= 1'b1;
        end else if (w_load && r_hold_full) begin
            r_hold_full <= 1'b0;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_spi_frame_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_frame_tx
// Description : Scoreboard bench for spi_frame_tx: expected words queued at
//               handshake, SPI monitor reassembles frames and checks timing.
// Revision    : 1.0  initial release
// ============================================================================
module tb_spi_frame_tx;
    localparam int DATA_W  = 16;
    localparam int CLK_DIV = 2;
    localparam int GAP_CYC = 2;
    localparam int C_LOW   = CLK_DIV * (2 * DATA_W + 1);

    logic clk;
    logic reset;

    spi_frame_tx_if #(.DATA_W(DATA_W)) bus ();

    spi_frame_tx #(
        .DATA_W  (DATA_W),
        .CLK_DIV (CLK_DIV),
        .GAP_CYC (GAP_CYC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int               n_checks = 0;
    int               n_fail   = 0;
    logic [DATA_W-1:0] exp_q[$];
    int               frames_sent   = 0;
    int               frames_seen   = 0;
    int               spurious_done = 0;
    int               viol          = 0;
    int               low_cnt       = 0;
    int               hi_cnt        = 1000;
    int               nedge         = 0;
    int               last_gap      = 0;
    logic             in_frame      = 1'b0;
    logic             last_ready_cs = 1'b1;
    logic             last_ready_busy = 1'b0;
    logic [DATA_W-1:0] cap;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Monitor: reconstructs each frame from sdo at sclk rise
    initial begin
        logic p_cs, p_sclk, p_sdo;
        p_cs = 1'b1; p_sclk = 1'b0; p_sdo = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                in_frame = 1'b0;
                hi_cnt   = 1000;
            end else begin
                if (bus.cs != p_cs && bus.sclk) viol++;
                if (p_sclk && bus.sclk && bus.sdo != p_sdo) viol++;
                if (bus.done && !(!p_cs && bus.cs)) spurious_done++;
                if (p_cs && !bus.cs) begin
                    chk("gap_min", 32'(hi_cnt >= GAP_CYC), 1);
                    last_gap = hi_cnt;
                    in_frame = 1'b1;
                    low_cnt  = 0;
                    nedge    = 0;
                    cap      = '0;
                end
                if (!bus.cs) low_cnt++;
                else         hi_cnt++;
                if (!bus.cs && !p_sclk && bus.sclk) begin
                    cap = {cap[DATA_W-2:0], bus.sdo};
                    nedge++;
                end
                if (!p_cs && bus.cs && in_frame) begin
                    in_frame = 1'b0;
                    hi_cnt   = 1;
                    frames_seen++;
                    chk("done_at_cs_rise", bus.done, 1);
                    chk("cs_low_cycles", low_cnt, C_LOW);
                    chk("sclk_rises", nedge, DATA_W);
                    chk("timing_viol", viol, 0);
                    viol = 0;
                    chk("frame_expected", 32'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) chk("frame_data", cap, exp_q.pop_front());
                end
            end
            p_cs = bus.cs; p_sclk = bus.sclk; p_sdo = bus.sdo;
        end
    end

    // All tasks enter and leave one time unit after a rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DATA_W-1:0] w);
        int n;
        bus.tx_valid = 1'b1;
        bus.tx_data  = w;
        n = 0;
        while (!bus.tx_ready && n < 5000) begin
            step();
            n++;
        end
        last_ready_cs   = bus.cs;
        last_ready_busy = bus.busy;
        chk("send_ready", bus.tx_ready, 1);
        @(posedge clk);
        if (bus.tx_ready) begin
            exp_q.push_back(w);
            frames_sent++;
        end
        #1;
        bus.tx_valid = 1'b0;
        bus.tx_data  = DATA_W'($urandom);
    endtask

    task automatic garbage(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            if (!bus.tx_ready) begin
                bus.tx_valid = 1'($urandom);
                bus.tx_data  = DATA_W'($urandom);
            end else begin
                bus.tx_valid = 1'b0;
            end
            step();
        end
        bus.tx_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || bus.busy) && n < 20000) begin
            step();
            n++;
        end
        chk("idle_busy", bus.busy, 0);
    endtask

    initial begin
        int k;
        reset        = 1'b0;
        bus.tx_valid = 1'b0;
        bus.tx_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cs", bus.cs, 1);
        chk("rst_sclk", bus.sclk, 0);
        chk("rst_sdo", bus.sdo, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_ready", bus.tx_ready, 0);
        reset = 1'b1;
        step();

        // Single frame, then handshake readiness after the gap
        send(16'h00BD);
        k = 0;
        while (!bus.done && k < 1000) begin step(); k++; end
        chk("done_seen", bus.done, 1);
        k = 0;
        while (!(bus.tx_ready && !bus.busy) && k < 50) begin step(); k++; end
        chk("ready_after_done", k, GAP_CYC);
        wait_idle();

        // Back-to-back words
        send(16'hFFFF);
        send(16'h8001);
        wait_idle();
`ifdef SPI_TX_HOLD_EN
        chk("b2b_gap", last_gap, GAP_CYC);
`else
        chk("b2b_gap_min", 32'(last_gap >= GAP_CYC + 1), 1);
`endif

        // Reset in the middle of a frame
        send(16'hA5C3);
        k = 0;
        while (!(in_frame && nedge >= 5) && k < 1000) begin step(); k++; end
        chk("midframe_reached", 32'(nedge >= 5), 1);
        reset = 1'b0;
        step();
        chk("mrst_cs", bus.cs, 1);
        chk("mrst_sclk", bus.sclk, 0);
        chk("mrst_sdo", bus.sdo, 0);
        chk("mrst_busy", bus.busy, 0);
        chk("mrst_done", bus.done, 0);
        exp_q.delete();
        frames_sent--;
        reset = 1'b1;
        step();
        send(16'h1234);
        wait_idle();

        // Valid toggling while not ready must never be accepted
        send(DATA_W'($urandom));
`ifdef SPI_TX_HOLD_EN
        send(DATA_W'($urandom));
`endif
        garbage(60);
        wait_idle();

`ifdef SPI_TX_HOLD_EN
        // Third word offered while one is held
        send(16'h0F0F);
        send(16'hC3C3);
        chk("ready_low_held", bus.tx_ready, 0);
        send(16'h7E81);
        chk("ready_return_cs", last_ready_cs, 0);
        chk("ready_return_busy", last_ready_busy, 1);
        wait_idle();
`endif

        // Random frames with random idle spacing
        for (int i = 0; i < 200; i++) begin
            send(DATA_W'($urandom));
            repeat ($urandom_range(0, 3)) step();
        end
        wait_idle();

        repeat (5) step();
        chk("frames_seen", frames_seen, frames_sent);
        chk("spurious_done", spurious_done, 0);
        chk("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        n_fail++;
        $display("FAIL global_timeout: got running, expected finished");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
